// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// A miss triggers a single-word fill from the memory controller. Hit and fill events are counted.
module icache #(
  parameter int FRAMES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX  = $clog2(FRAMES);
  localparam int TAGW = 30 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_q, state_d;
  logic [29:0]       fill_addr_q, fill_addr_d;
  logic [31:0]       hit_count_q, hit_count_d;
  logic [31:0]       miss_count_q, miss_count_d;
  logic [FRAMES-1:0] valid_q;
  logic [TAGW-1:0]   tag_q  [FRAMES];
  logic [31:0]       data_q [FRAMES];

  logic [IDX-1:0]    req_idx, fill_idx;
  logic [TAGW-1:0]   req_tag, fill_tag;
  logic              lookup_hit;
  logic              fill_done;
  logic              unused_addr_bits;

  // The byte offset within a word plays no part in the lookup.
  assign unused_addr_bits = ^imemaddr[1:0];

  assign req_idx  = imemaddr[IDX+1:2];
  assign req_tag  = imemaddr[31:IDX+2];
  assign fill_idx = fill_addr_q[IDX-1:0];
  assign fill_tag = fill_addr_q[29:IDX];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Frame storage. Only the valid bits need a reset because tag and data are ignored while invalid.
  for (genvar gi = 0; gi < FRAMES; gi++) begin : g_frame
    logic frame_we;
    assign frame_we = fill_done && (fill_idx == IDX'(gi));

    always_ff @(posedge CLK) begin
      if (RST) begin
        valid_q[gi] <= 1'b0;
      end else if (frame_we) begin
        valid_q[gi] <= 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (frame_we) begin
        tag_q[gi]  <= fill_tag;
        data_q[gi] <= iload;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !lookup_hit) begin
          state_d     = FETCH;
          fill_addr_d = imemaddr[31:2];
        end
      end
      FETCH: begin
        if (!iwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ihit      = 1'b0;
    imemload  = '0;
    iREN      = 1'b0;
    iaddr     = '0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        ihit = imemREN && lookup_hit;
        if (ihit) begin
          imemload = data_q[req_idx];
        end
      end
      FETCH: begin
        iREN      = 1'b1;
        iaddr     = {fill_addr_q, 2'b00};
        fill_done = !iwait;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_count_d  = hit_count_q + 32'(ihit);
    miss_count_d = miss_count_q + 32'(fill_done);
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a per-cycle vector table for miss/hit/eviction flows,
// followed by hand-written sequences for redirect, reset, idle and stall corner cases.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 CLK = ~CLK;

  icache #(.FRAMES(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic        w;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_h;
    logic [31:0] e_m;
  } vec_t;

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam int NVEC = 18;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic ren, input logic [31:0] addr, input logic w,
                              input logic [31:0] ld, input logic e_hit, input logic [31:0] e_load,
                              input logic e_iren, input logic [31:0] e_iaddr,
                              input logic [31:0] e_h, input logic [31:0] e_m);
    vec_t v;
    v.ren = ren; v.addr = addr; v.w = w; v.ld = ld;
    v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
    v.e_h = e_h; v.e_m = e_m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic rst, input logic ren, input logic [31:0] addr,
                       input logic w, input logic [31:0] ld);
    RST = rst; imemREN = ren; imemaddr = addr; iwait = w; iload = ld;
    @(negedge CLK);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Cold miss on 0x40 with two wait cycles, then hits.
    vecs[0]  = mk(0, 32'h00, 1, D,            0, 0,            0, 0,     0, 0);
    vecs[1]  = mk(1, 32'h40, 1, D,            0, 0,            0, 0,     0, 0);
    vecs[2]  = mk(1, 32'h40, 1, D,            0, 0,            1, 32'h40, 0, 0);
    vecs[3]  = mk(1, 32'h40, 1, D,            0, 0,            1, 32'h40, 0, 0);
    vecs[4]  = mk(1, 32'h40, 0, 32'h8C220004, 0, 0,            1, 32'h40, 0, 0);
    vecs[5]  = mk(1, 32'h40, 1, D,            1, 32'h8C220004, 0, 0,     0, 1);
    vecs[6]  = mk(1, 32'h40, 1, D,            1, 32'h8C220004, 0, 0,     1, 1);
    // Conflict eviction: 0x04 and 0x44 share frame 1.
    vecs[7]  = mk(1, 32'h04, 1, D,            0, 0,            0, 0,     2, 1);
    vecs[8]  = mk(1, 32'h04, 0, 32'h11111111, 0, 0,            1, 32'h04, 2, 1);
    vecs[9]  = mk(1, 32'h04, 1, D,            1, 32'h11111111, 0, 0,     2, 2);
    vecs[10] = mk(1, 32'h44, 1, D,            0, 0,            0, 0,     3, 2);
    vecs[11] = mk(1, 32'h44, 0, 32'h22222222, 0, 0,            1, 32'h44, 3, 2);
    vecs[12] = mk(1, 32'h44, 1, D,            1, 32'h22222222, 0, 0,     3, 3);
    vecs[13] = mk(1, 32'h04, 1, D,            0, 0,            0, 0,     4, 3);
    vecs[14] = mk(1, 32'h04, 0, 32'h11111111, 0, 0,            1, 32'h04, 4, 3);
    vecs[15] = mk(1, 32'h04, 1, D,            1, 32'h11111111, 0, 0,     4, 4);
    vecs[16] = mk(1, 32'h40, 1, D,            1, 32'h8C220004, 0, 0,     5, 4);
    // Byte-offset bits are ignored by the lookup.
    vecs[17] = mk(1, 32'h43, 1, D,            1, 32'h8C220004, 0, 0,     6, 4);

    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    step();
    step();

    for (int i = 0; i < NVEC; i++) begin
      drive(1'b0, vecs[i].ren, vecs[i].addr, vecs[i].w, vecs[i].ld);
      $display("vec %0d: ren=%0b addr=%08h ihit=%0b load=%08h iREN=%0b iaddr=%08h hits=%0d misses=%0d",
               i, vecs[i].ren, vecs[i].addr, ihit, imemload, iREN, iaddr, hit_count, miss_count);
      chk($sformatf("vec%0d ihit", i), 32'(ihit), 32'(vecs[i].e_hit));
      chk($sformatf("vec%0d imemload", i), imemload, vecs[i].e_load);
      chk($sformatf("vec%0d iREN", i), 32'(iREN), 32'(vecs[i].e_iren));
      chk($sformatf("vec%0d iaddr", i), iaddr, vecs[i].e_iaddr);
      chk($sformatf("vec%0d hit_count", i), hit_count, vecs[i].e_h);
      chk($sformatf("vec%0d miss_count", i), miss_count, vecs[i].e_m);
      step();
    end

    // Redirect mid-fill: 0x100 (frame 0) fills, then 0x204 (frame 1) is looked up afterwards.
    $display("seq redirect: miss 0x100, PC moves to 0x204 during fill");
    drive(0, 1, 32'h100, 1, D);
    chk("redir miss ihit", 32'(ihit), 0);
    chk("redir miss iREN", 32'(iREN), 0);
    step();
    drive(0, 1, 32'h204, 1, D);
    chk("redir fetch iREN", 32'(iREN), 1);
    chk("redir fetch iaddr", iaddr, 32'h100);
    chk("redir fetch ihit", 32'(ihit), 0);
    step();
    drive(0, 1, 32'h204, 0, 32'hAAAA0001);
    chk("redir done iaddr", iaddr, 32'h100);
    chk("redir done ihit", 32'(ihit), 0);
    chk("redir done miss_count", miss_count, 4);
    step();
    drive(0, 1, 32'h204, 1, D);
    chk("redir new ihit", 32'(ihit), 0);
    chk("redir new iREN", 32'(iREN), 0);
    chk("redir new miss_count", miss_count, 5);
    step();
    drive(0, 1, 32'h204, 0, 32'hBBBB0002);
    chk("redir new iaddr", iaddr, 32'h204);
    step();
    drive(0, 1, 32'h100, 1, D);
    chk("redir old ihit", 32'(ihit), 1);
    chk("redir old load", imemload, 32'hAAAA0001);
    chk("redir old iREN", 32'(iREN), 0);
    chk("redir old miss_count", miss_count, 6);
    chk("redir old hit_count", hit_count, 7);
    step();
    drive(0, 1, 32'h204, 1, D);
    chk("redir 204 load", imemload, 32'hBBBB0002);
    step();

    // Idle request to a resident address.
    $display("seq idle: imemREN=0 on resident 0x100");
    drive(0, 0, 32'h100, 1, D);
    chk("idle ihit", 32'(ihit), 0);
    chk("idle load", imemload, 0);
    chk("idle iREN", 32'(iREN), 0);
    chk("idle hit_count", hit_count, 9);
    step();
    drive(0, 0, 32'h100, 1, D);
    chk("idle after iREN", 32'(iREN), 0);
    chk("idle after hit_count", hit_count, 9);
    step();

    // Stalled PC: five consecutive hit cycles.
    $display("seq stall: hold 0x100 for 5 cycles");
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h100, 1, D);
      chk($sformatf("stall%0d ihit", i), 32'(ihit), 1);
      step();
    end
    drive(0, 0, 32'h100, 1, D);
    chk("stall hit_count", hit_count, 14);
    chk("stall miss_count", miss_count, 6);
    step();

    // Reset in the second FETCH cycle while memory is still busy.
    $display("seq reset mid-fill (iwait=1) on 0x300");
    drive(0, 1, 32'h300, 1, D);
    chk("rst1 miss ihit", 32'(ihit), 0);
    step();
    drive(0, 1, 32'h300, 1, D);
    chk("rst1 fetch iaddr", iaddr, 32'h300);
    step();
    drive(1, 1, 32'h300, 1, D);
    chk("rst1 during iREN", 32'(iREN), 1);
    step();
    drive(0, 0, 32'h300, 1, D);
    chk("rst1 after iREN", 32'(iREN), 0);
    chk("rst1 after iaddr", iaddr, 0);
    chk("rst1 after miss_count", miss_count, 0);
    chk("rst1 after hit_count", hit_count, 0);
    step();
    drive(0, 1, 32'h100, 1, D);
    chk("rst1 wiped 0x100 ihit", 32'(ihit), 0);
    step();
    drive(0, 1, 32'h100, 0, 32'hCCCC0003);
    chk("rst1 refill iaddr", iaddr, 32'h100);
    step();
    drive(0, 1, 32'h300, 1, D);
    chk("rst1 0x300 ihit", 32'(ihit), 0);
    chk("rst1 0x300 miss_count", miss_count, 1);
    step();
    drive(0, 1, 32'h300, 0, 32'hDDDD0004);
    chk("rst1 0x300 iaddr", iaddr, 32'h300);
    step();
    drive(0, 1, 32'h300, 1, D);
    chk("rst1 0x300 hit", 32'(ihit), 1);
    chk("rst1 0x300 load", imemload, 32'hDDDD0004);
    chk("rst1 0x300 miss_count", miss_count, 2);
    step();

    // Reset in the completing FETCH cycle: fill discarded, not counted.
    $display("seq reset mid-fill (iwait=0) on 0x400");
    drive(0, 1, 32'h400, 1, D);
    chk("rst2 miss ihit", 32'(ihit), 0);
    step();
    drive(1, 1, 32'h400, 0, 32'hEEEE0005);
    chk("rst2 during iaddr", iaddr, 32'h400);
    step();
    drive(0, 1, 32'h400, 1, D);
    chk("rst2 after ihit", 32'(ihit), 0);
    chk("rst2 after iREN", 32'(iREN), 0);
    chk("rst2 after miss_count", miss_count, 0);
    chk("rst2 after hit_count", hit_count, 0);
    step();
    drive(0, 1, 32'h400, 0, 32'hEEEE0005);
    chk("rst2 refill iREN", 32'(iREN), 1);
    step();
    drive(0, 1, 32'h400, 1, D);
    chk("rst2 hit", 32'(ihit), 1);
    chk("rst2 load", imemload, 32'hEEEE0005);
    chk("rst2 miss_count", miss_count, 1);
    chk("rst2 hit_count", hit_count, 0);
    step();

    // Reset coinciding with a hit: ihit still shows, counter clears.
    $display("seq reset with hit on 0x400");
    drive(1, 1, 32'h400, 1, D);
    chk("rsthit ihit", 32'(ihit), 1);
    chk("rsthit load", imemload, 32'hEEEE0005);
    chk("rsthit hit_count", hit_count, 1);
    step();
    drive(0, 1, 32'h400, 1, D);
    chk("rsthit after hit_count", hit_count, 0);
    chk("rsthit after miss_count", miss_count, 0);
    chk("rsthit after ihit", 32'(ihit), 0);
    step();
    drive(0, 0, 32'h0, 0, D);
    chk("rsthit refetch iaddr", iaddr, 32'h400);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache: the responder side of the datapath's instruction-fetch port. It answers `imemREN`/`imemaddr` requests with `ihit`/`imemload`. On a miss it runs a fill handshake with the memory controller (`iREN`/`iaddr`/`iwait`/`iload`), and it keeps hit and miss counters for performance tests.

## Interface
- `FRAMES`, 16: number of one-word frames; power of two, at least 2. `IDX = log2(FRAMES)`.
- `CLK`  in  1  clock; all state updates on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `imemREN`  in  1  datapath instruction read request.
- `imemaddr`  in  32  fetch byte address; bits [1:0] are ignored.
- `ihit`  out  1  `imemload` is valid for `imemaddr` this cycle.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  fill read request to the memory controller.
- `iaddr`  out  32  fill word address; bits [1:0] = 0.
- `iwait`  in  1  memory busy; a fill completes in the first FETCH cycle with `iwait`=0.
- `iload`  in  32  fill data, valid when `iREN`=1 and `iwait`=0.
- `hit_count`  out  32  number of cycles with `ihit`=1.
- `miss_count`  out  32  number of completed fills.

## Operation
- Address split: index = `imemaddr[IDX+1:2]`, tag = `imemaddr[31:IDX+2]`.
- Each frame holds a valid bit, a tag and a 32-bit data word.
- Lookup is combinational:
  - `ihit` = `imemREN` & valid[index] & (tag[index] == tag) & (state == IDLE).
  - `imemload` = data[index] when `ihit`=1, else 0.
- State machine: IDLE and FETCH.
  - IDLE to FETCH: `imemREN`=1 and lookup misses. Latch `fill_addr` = {`imemaddr[31:2]`, 2'b00}.
  - IDLE otherwise: stay in IDLE.
  - FETCH: drive `iREN`=1 and `iaddr`=`fill_addr`. When `iwait`=0, write {valid=1, tag, `iload`} into the frame selected by `fill_addr`, increment `miss_count`, and return to IDLE.
  - FETCH with `iwait`=1: hold state; `iREN` and `iaddr` stay stable.
- Outside FETCH: `iREN`=0 and `iaddr`=0.
- No write path. Instruction memory is read-only from the datapath.
- Counters are 32-bit and wrap modulo 2^32.
  - `hit_count` increments in every cycle where `ihit`=1, including repeated hits while the datapath holds the PC during a data stall.

## Timing
- Reset values (state after a cycle with `RST`=1):
  - state = IDLE.
  - All valid bits = 0. Tags and data are don't-care and are not observable while invalid.
  - `hit_count` = 0, `miss_count` = 0.
  - Outputs: `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- Hit latency is 0 cycles: `ihit` rises in the same cycle the request and matching address are presented.
- Miss latency, with W = number of FETCH cycles where `iwait`=1:
  - Cycle 0: request in IDLE; miss detected.
  - Cycles 1 to 1+W: FETCH.
  - Cycle 2+W: IDLE; lookup hits and `ihit`=1.
- `ihit` is 0 in every FETCH cycle, including the completing cycle. Data is never forwarded straight from `iload`.
- `imemaddr` changes during FETCH (e.g. a branch flush redirects the PC): the fill for the latched `fill_addr` still completes and is written. The new address is looked up in the following IDLE cycle.
- `imemREN` drops during FETCH: the fill completes normally.
- Conflict eviction: a fill overwrites the frame unconditionally, whatever it held before.
- `RST` during FETCH: takes priority over everything else.
  - Next cycle is IDLE with all frames invalid.
  - `iREN` = 0 from that cycle on.
  - The in-flight fill is discarded, and `miss_count` does not increment even if `iwait`=0 in the reset cycle.
- `RST` and a hit in the same cycle: `ihit` is still combinationally 1 in that cycle, but `hit_count` resets to 0 and does not increment.

## Test plan
- Cold miss then hit:
  - Stimulus: after reset, `imemREN`=1, `imemaddr`=0x00000040. Memory returns 0x8C220004 with `iwait`=1 for 2 cycles.
  - Required: `iREN`=1 and `iaddr`=0x40 for cycles 1–3; `ihit`=1 with `imemload`=0x8C220004 at cycle 4; `miss_count`=1; `hit_count` counting from cycle 4.
- Conflict eviction (`FRAMES`=16):
  - Stimulus: fill 0x00000004 with 0x11111111, then request 0x00000044.
  - Required: a miss and a fill of 0x00000044.
  - Stimulus: re-request 0x00000004.
  - Required: a miss again; `miss_count`=3.
- Address change mid-fill:
  - Stimulus: miss on 0x100; during FETCH, switch `imemaddr` to 0x200.
  - Required: frame for 0x100 is filled. Next IDLE cycle misses on 0x200 and `iaddr`=0x200. A later request to 0x100 hits with no fill.
- Reset mid-fill:
  - Stimulus: assert `RST` in the second FETCH cycle while `iwait`=1.
  - Required next cycle: `iREN`=0, state IDLE, `miss_count`=0. A subsequent request to the same address misses.
- Idle request:
  - Stimulus: `imemREN`=0 with a valid-matching address.
  - Required: `ihit`=0, `imemload`=0, no fill started, `hit_count` unchanged.
- Stall hit counting:
  - Stimulus: hold a hit address for 5 cycles.
  - Required: `hit_count` increases by exactly 5; `miss_count` unchanged.
